// File: rtl/mem_access_unit.sv
// ============================================================================
//  Module      : mem_access_unit
//  Description : Load/store sequencer between the memory stage and a
//                byte-addressed little-endian data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
   parameter int MEM_SIZE = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [63:0] resp_rdata,
   output logic [63:0] mem_address,
   output logic        mem_write_enable,
   output logic        mem_read_enable,
   output logic [63:0] mem_write_data,
   output logic [3:0]  mem_xfer_size,
   input  logic [63:0] mem_read_data
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic        r_write;
   logic [63:0] r_addr;
   logic [1:0]  r_size;
   logic        r_signed;
   logic [63:0] r_wdata;
   logic        r_err;
   logic        r_aligned;
   logic [2:0]  r_cnt;
   logic [63:0] r_result;

   logic [3:0]  w_req_n;
   logic [64:0] w_req_end;
   logic        w_oob;
   logic        w_req_aligned;
   logic [3:0]  w_n;
   logic        w_last;
   logic [7:0]  w_wbyte;
   logic [63:0] w_ext;

   // 65-bit sum so addresses near 2^64 cannot wrap into range
   assign w_req_n       = 4'd1 << req_size;
   assign w_req_end     = {1'b0, req_addr} + 65'(w_req_n);
   assign w_oob         = w_req_end > 65'(MEM_SIZE);
   assign w_req_aligned = (req_addr[2:0] & 3'(w_req_n - 4'd1)) == 3'd0;

   assign w_n     = 4'd1 << r_size;
   assign w_last  = r_aligned || (r_cnt == 3'(w_n - 4'd1));
   assign w_wbyte = r_wdata[{r_cnt, 3'b000} +: 8];

   always_comb begin
      w_ext = 64'd0;
      case (r_size)
         2'd0: w_ext = {{56{r_signed & r_result[7]}},  r_result[7:0]};
         2'd1: w_ext = {{48{r_signed & r_result[15]}}, r_result[15:0]};
         2'd2: w_ext = {{32{r_signed & r_result[31]}}, r_result[31:0]};
         default: w_ext = r_result;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (req_valid) w_next = w_oob ? S_RESP : S_ACCESS;
         S_ACCESS: if (w_last) w_next = S_RESP;
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_write   <= 1'b0;
         r_addr    <= 64'd0;
         r_size    <= 2'd0;
         r_signed  <= 1'b0;
         r_wdata   <= 64'd0;
         r_err     <= 1'b0;
         r_aligned <= 1'b0;
         r_cnt     <= 3'd0;
         r_result  <= 64'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_write   <= req_write;
                  r_addr    <= req_addr;
                  r_size    <= req_size;
                  r_signed  <= req_signed;
                  r_wdata   <= req_wdata;
                  r_err     <= w_oob;
                  r_aligned <= w_req_aligned;
                  r_cnt     <= 3'd0;
                  r_result  <= 64'd0;
               end
            end
            S_ACCESS: begin
               // Aligned loads keep the whole word; the size mask is applied on response
               if (!r_write) begin
                  if (r_aligned) begin
                     r_result <= mem_read_data;
                  end else begin
                     r_result[{r_cnt, 3'b000} +: 8] <= mem_read_data[7:0];
                  end
               end
               r_cnt <= r_cnt + 3'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      req_ready        = 1'b0;
      resp_valid       = 1'b0;
      resp_err         = 1'b0;
      resp_rdata       = 64'd0;
      mem_address      = 64'd0;
      mem_write_enable = 1'b0;
      mem_read_enable  = 1'b0;
      mem_write_data   = 64'd0;
      mem_xfer_size    = 4'd8;
      case (r_state)
         S_IDLE: req_ready = 1'b1;
         S_ACCESS: begin
            mem_write_enable = r_write;
            mem_read_enable  = ~r_write;
            if (r_aligned) begin
               mem_address    = r_addr;
               mem_xfer_size  = w_n;
               mem_write_data = r_wdata;
            end else begin
               mem_address    = r_addr + 64'(r_cnt);
               mem_xfer_size  = 4'd1;
               mem_write_data = {56'd0, w_wbyte};
            end
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_err   = r_err;
            resp_rdata = (r_err || r_write) ? 64'd0 : w_ext;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire
